// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage issue control: load-use, MDU RAW/WAW/structural hazards, branch flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard #(
  parameter int LONG_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_is_long,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_mem_read,
  input  logic        ex_long_issue,
  input  logic [4:0]  ex_long_rd,
  input  logic        lu_wb_valid,
  input  logic [4:0]  lu_wb_rd,
  input  logic        ex_branch_taken,
  output logic        pc_write_en,
  output logic        if_id_write_en,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        long_busy,
  output logic [31:0] sb_pending,
  output logic        timeout_err
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] perf_stall_cycles
  , output logic [CNT_W-1:0] perf_load_use
`endif
);

  localparam int TW = $clog2(LONG_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(LONG_TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         r_state;
  logic           r_long_busy;
  logic [31:0]    r_sb_pending;
  logic [TW-1:0]  r_to_cnt;
  logic           r_timeout_err;

  logic [31:0]    w_issue_mask;
  logic [31:0]    w_clr_mask;
  logic [31:0]    w_pend_eff;
  logic           w_load_use;
  logic           w_raw;
  logic           w_waw;
  logic           w_struct;
  logic           w_stall;
  logic [TW-1:0]  w_to_cnt_next;

  // x0 is excluded here so it can never pend or match through the scoreboard.
  assign w_issue_mask = (ex_long_issue && ex_long_rd != 5'd0) ? (32'd1 << ex_long_rd) : 32'd0;
  assign w_clr_mask   = lu_wb_valid ? (32'd1 << lu_wb_rd) : 32'd0;
  assign w_pend_eff   = r_sb_pending | w_issue_mask;

  assign w_load_use = id_valid && id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((id_use_rs1 && id_rs1 == id_ex_rd) || (id_use_rs2 && id_rs2 == id_ex_rd));
  assign w_raw      = id_valid && ((id_use_rs1 && w_pend_eff[id_rs1]) ||
                                   (id_use_rs2 && w_pend_eff[id_rs2]));
  assign w_waw      = id_valid && id_reg_write && w_pend_eff[id_rd];
  assign w_struct   = id_valid && id_is_long && (r_long_busy || ex_long_issue);
  assign w_stall    = w_load_use || w_raw || w_waw || w_struct;

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_bubble   = 1'b0;
    if_id_flush    = 1'b0;
    if (!rst) begin
      if (ex_branch_taken) begin
        id_ex_bubble = 1'b1;
        if_id_flush  = 1'b1;
      end else if (w_stall) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
      end
    end
  end

  always_comb begin
    w_to_cnt_next = r_to_cnt;
    if (ex_long_issue || r_state == IDLE) begin
      w_to_cnt_next = '0;
    end else if (r_to_cnt != TO_MAX) begin
      w_to_cnt_next = r_to_cnt + 1'b1;
    end
  end

  // Issue wins over writeback on the same register so back-to-back ops keep their bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_pending <= '0;
    end else begin
      r_sb_pending <= (r_sb_pending & ~w_clr_mask) | w_issue_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_long_busy   <= 1'b0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_long_issue) begin
            r_state     <= BUSY;
            r_long_busy <= 1'b1;
          end
        end
        BUSY: begin
          if (lu_wb_valid && !ex_long_issue) begin
            r_state     <= IDLE;
            r_long_busy <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_long_busy <= 1'b0;
        end
      endcase
      r_to_cnt <= w_to_cnt_next;
      if (w_to_cnt_next == TO_MAX) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign long_busy   = r_long_busy;
  assign sb_pending  = r_sb_pending;
  assign timeout_err = r_timeout_err;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_lu;
  logic             r_lu_stall_d;
  logic             w_lu_stall;

  assign w_lu_stall = w_load_use && !ex_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_lu    <= '0;
      r_lu_stall_d <= 1'b0;
    end else begin
      r_lu_stall_d <= w_lu_stall;
      if (w_stall && !ex_branch_taken) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
      if (w_lu_stall && !r_lu_stall_d) begin
        r_perf_lu <= r_perf_lu + 1'b1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_load_use     = r_perf_lu;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed-vector bench for hazard_scoreboard (LONG_TIMEOUT=8).
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_ex_rd, ex_long_rd, lu_wb_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write, id_is_long, id_ex_mem_read;
  logic        ex_long_issue, lu_wb_valid, ex_branch_taken;
  logic        pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush;
  logic        long_busy, timeout_err;
  logic [31:0] sb_pending;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_load_use;
`endif

  int vectors = 0;
  int miscompares = 0;

  // {pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush}
  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] STALL = 4'b0010;
  localparam logic [3:0] FLUSH = 4'b1111;

  logic [3:0] ctrl;
  assign ctrl = {pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush};

  hazard_scoreboard #(.LONG_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_long(id_is_long),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_long_issue(ex_long_issue), .ex_long_rd(ex_long_rd),
    .lu_wb_valid(lu_wb_valid), .lu_wb_rd(lu_wb_rd),
    .ex_branch_taken(ex_branch_taken),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .long_busy(long_busy), .sb_pending(sb_pending), .timeout_err(timeout_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_load_use(perf_load_use)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_is_long = 0; id_ex_rd = 0; id_ex_mem_read = 0;
    ex_long_issue = 0; ex_long_rd = 0; lu_wb_valid = 0; lu_wb_rd = 0; ex_branch_taken = 0;
  endtask

  task automatic id_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1; id_rd = rd; id_reg_write = 1; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = 1; id_use_rs2 = 1; id_is_long = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    id_add(5'd6, 5'd5, 5'd7);
    id_ex_mem_read = 1; id_ex_rd = 5'd5;
    #2;
    vectors++; if (ctrl !== RUN) begin miscompares++; $display("FAIL rst_ctrl got %b exp %b", ctrl, RUN); end
    vectors++; if (sb_pending !== 32'd0) begin miscompares++; $display("FAIL rst_sb got %h exp 0", sb_pending); end
    vectors++; if (long_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", long_busy); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_tmo got %b exp 0", timeout_err); end
    tick();
    idle_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    id_add(5'd6, 5'd5, 5'd7);
    id_ex_mem_read = 1; id_ex_rd = 5'd5;
    #1;
    vectors++; if (ctrl !== STALL) begin miscompares++; $display("FAIL lu_stall got %b exp %b", ctrl, STALL); end
    tick();
    id_ex_mem_read = 0; id_ex_rd = 5'd0;
    #1;
    vectors++; if (ctrl !== RUN) begin miscompares++; $display("FAIL lu_release got %b exp %b", ctrl, RUN); end
    id_ex_mem_read = 1; id_ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    vectors++; if (ctrl !== RUN) begin miscompares++; $display("FAIL lu_x0 got %b exp %b", ctrl, RUN); end
    id_ex_rd = 5'd7; id_use_rs2 = 0;
    #1;
    vectors++; if (ctrl !== RUN) begin miscompares++; $display("FAIL lu_unused_rs2 got %b exp %b", ctrl, RUN); end
    tick();
  endtask

  task automatic test_mdu_raw();
    idle_inputs();
    ex_long_issue = 1; ex_long_rd = 5'd10;
    id_add(5'd11, 5'd10, 5'd1);
    #1;
    vectors++; if (ctrl !== STALL) begin miscompares++; $display("FAIL raw_issue got %b exp %b", ctrl, STALL); end
    tick();
    ex_long_issue = 0;
    #1;
    vectors++; if (sb_pending !== 32'h0000_0400) begin miscompares++; $display("FAIL raw_sb_set got %h exp 00000400", sb_pending); end
    vectors++; if (long_busy !== 1'b1) begin miscompares++; $display("FAIL raw_busy got %b exp 1", long_busy); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (ctrl !== STALL) begin miscompares++; $display("FAIL raw_hold%0d got %b exp %b", i, ctrl, STALL); end
      tick();
    end
    lu_wb_valid = 1; lu_wb_rd = 5'd10;
    #1;
    vectors++; if (ctrl !== STALL) begin miscompares++; $display("FAIL raw_wb_cycle got %b exp %b", ctrl, STALL); end
    tick();
    lu_wb_valid = 0;
    #1;
    vectors++; if (ctrl !== RUN) begin miscompares++; $display("FAIL raw_release got %b exp %b", ctrl, RUN); end
    vectors++; if (sb_pending !== 32'd0) begin miscompares++; $display("FAIL raw_sb_clr got %h exp 0", sb_pending); end
    vectors++; if (long_busy !== 1'b0) begin miscompares++; $display("FAIL raw_idle got %b exp 0", long_busy); end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    ex_long_issue = 1; ex_long_rd = 5'd3;
    id_add(5'd9, 5'd1, 5'd2); id_is_long = 1;
    #1;
    vectors++; if (ctrl !== STALL) begin miscompares++; $display("FAIL st_issue got %b exp %b", ctrl, STALL); end
    tick();
    ex_long_issue = 0;
    #1;
    vectors++; if (ctrl !== STALL) begin miscompares++; $display("FAIL st_busy got %b exp %b", ctrl, STALL); end
    lu_wb_valid = 1; lu_wb_rd = 5'd3;
    #1;
    vectors++; if (ctrl !== STALL) begin miscompares++; $display("FAIL st_wb_cycle got %b exp %b", ctrl, STALL); end
    tick();
    lu_wb_valid = 0;
    #1;
    vectors++; if (ctrl !== RUN) begin miscompares++; $display("FAIL st_release got %b exp %b", ctrl, RUN); end
    tick();
    idle_inputs();
    ex_long_issue = 1; ex_long_rd = 5'd3;
    tick();
    lu_wb_valid = 1; lu_wb_rd = 5'd3;
    tick();
    ex_long_issue = 0;
    #1;
    vectors++; if (long_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %b exp 1", long_busy); end
    vectors++; if (sb_pending !== 32'h0000_0008) begin miscompares++; $display("FAIL b2b_sb got %h exp 00000008", sb_pending); end
    tick();
    lu_wb_valid = 0;
    #1;
    vectors++; if (long_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got %b exp 0", long_busy); end
    vectors++; if (sb_pending !== 32'd0) begin miscompares++; $display("FAIL b2b_sb_clr got %h exp 0", sb_pending); end
  endtask

  task automatic test_x0_waw();
    idle_inputs();
    ex_long_issue = 1; ex_long_rd = 5'd0;
    id_add(5'd0, 5'd0, 5'd0);
    #1;
    vectors++; if (ctrl !== RUN) begin miscompares++; $display("FAIL x0_match got %b exp %b", ctrl, RUN); end
    tick();
    idle_inputs();
    #1;
    vectors++; if (sb_pending !== 32'd0) begin miscompares++; $display("FAIL x0_sb got %h exp 0", sb_pending); end
    lu_wb_valid = 1; lu_wb_rd = 5'd0;
    tick();
    idle_inputs();
    ex_long_issue = 1; ex_long_rd = 5'd4;
    tick();
    ex_long_issue = 0;
    id_valid = 1; id_rd = 5'd4; id_reg_write = 1; id_rs1 = 5'd1; id_use_rs1 = 1;
    #1;
    vectors++; if (sb_pending !== 32'h0000_0010) begin miscompares++; $display("FAIL waw_sb got %h exp 00000010", sb_pending); end
    vectors++; if (ctrl !== STALL) begin miscompares++; $display("FAIL waw_stall got %b exp %b", ctrl, STALL); end
    id_reg_write = 0;
    #1;
    vectors++; if (ctrl !== RUN) begin miscompares++; $display("FAIL waw_nowrite got %b exp %b", ctrl, RUN); end
    lu_wb_valid = 1; lu_wb_rd = 5'd4;
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    idle_inputs();
    id_add(5'd6, 5'd5, 5'd7);
    id_ex_mem_read = 1; id_ex_rd = 5'd5;
    ex_branch_taken = 1;
    ex_long_issue = 1; ex_long_rd = 5'd12;
    #1;
    vectors++; if (ctrl !== FLUSH) begin miscompares++; $display("FAIL flush_prio got %b exp %b", ctrl, FLUSH); end
    tick();
    idle_inputs();
    #1;
    vectors++; if (sb_pending !== 32'h0000_1000) begin miscompares++; $display("FAIL flush_sb got %h exp 00001000", sb_pending); end
    vectors++; if (long_busy !== 1'b1) begin miscompares++; $display("FAIL flush_busy got %b exp 1", long_busy); end
    lu_wb_valid = 1; lu_wb_rd = 5'd12;
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout_reset();
    idle_inputs();
    ex_long_issue = 1; ex_long_rd = 5'd7;
    tick();
    ex_long_issue = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_early%0d got %b exp 0", i, timeout_err); end
    end
    tick();
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_set got %b exp 1", timeout_err); end
    tick();
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky got %b exp 1", timeout_err); end
    #1;
    rst = 1;
    #1;
    vectors++; if (sb_pending !== 32'd0) begin miscompares++; $display("FAIL arst_sb got %h exp 0", sb_pending); end
    vectors++; if (long_busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy got %b exp 0", long_busy); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL arst_tmo got %b exp 0", timeout_err); end
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mdu_raw();
    test_back_to_back();
    test_x0_waw();
    test_flush();
    test_timeout_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
